des_system_top: RTL and testbench

//  Self-contained non-pipelined DES encryption system (FIPS 46-3). One start pulse makes it

---
 rtl/des_system_top.sv | 173 +++++++++++++++++
 tb/tb_des_system_top.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_system_top.sv
// rtl/des_system_top.sv - Iterative DES encryptor: reads mem[0], encrypts with KEY, writes mem[1]
module des_system_top #(
    parameter logic [63:0] KEY            = 64'h133457799BBCDFF1,
    parameter logic [63:0] INIT_PLAINTEXT = 64'h123456789ABCDEF0,
    parameter int          MEM_DEPTH      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_btn,
    output logic done_led
);
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // One S-box per entry, 64 nibbles in row-major order (row*16 + col), first nibble in the MSBs.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Tables number bits from 1 at the MSB, so table entry t selects vector bit (width - t).
    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] f_s(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        int          idx;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            b   = x[47-6*j -: 6];
            idx = int'({b[5], b[0], b[4:1]});
            y[31-4*j -: 4] = SBOX[j][255-4*idx -: 4];
        end
        return y;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_INIT, S_ROUND, S_WRITE, S_DONE} state_t;

    logic [63:0] mem [0:MEM_DEPTH-1] = '{0: INIT_PLAINTEXT, default: 64'h0};

    state_t      state_q;
    logic [4:0]  round_q;
    logic [31:0] l_q, r_q, l_d, r_d;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [47:0] sub_key;
    logic [63:0] rdata_q;
    logic        start_q, armed_q, done_led_q, shift2, start_det;

    // armed_q blocks a button that was already held while reset was released.
    assign start_det = start_btn & ~start_q & armed_q;
    assign done_led  = done_led_q;

    always_comb begin
        shift2  = !(round_q == 5'd1 || round_q == 5'd2 || round_q == 5'd9 || round_q == 5'd16);
        c_d     = shift2 ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
        d_d     = shift2 ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};
        sub_key = f_pc2({c_d, d_d});
        l_d     = r_q;
        r_d     = l_q ^ f_p(f_s(f_e(r_q) ^ sub_key));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            round_q    <= '0;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            start_q    <= 1'b0;
            armed_q    <= ~start_btn;
            done_led_q <= 1'b0;
        end else begin
            start_q    <= start_btn;
            armed_q    <= armed_q | ~start_btn;
            done_led_q <= 1'b0;
            case (state_q)
                S_IDLE:  if (start_det) state_q <= S_RD;
                S_RD:    state_q <= S_WAIT;
                S_WAIT:  state_q <= S_INIT;
                S_INIT: begin
                    {l_q, r_q} <= f_ip(rdata_q);
                    {c_q, d_q} <= f_pc1(KEY);
                    round_q    <= 5'd1;
                    state_q    <= S_ROUND;
                end
                S_ROUND: begin
                    l_q <= l_d;
                    r_q <= r_d;
                    c_q <= c_d;
                    d_q <= d_d;
                    if (round_q == 5'd16) begin
                        round_q <= '0;
                        state_q <= S_WRITE;
                    end else begin
                        round_q <= round_q + 5'd1;
                    end
                end
                S_WRITE: state_q <= S_DONE;
                S_DONE: begin
                    if (start_det) state_q <= S_RD;
                    else           done_led_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem[0];
        if (reset && state_q == S_WRITE) mem[1] <= f_fp({r_q, l_q});
    end

endmodule

// File: tb/tb_des_system_top.sv
// tb/tb_des_system_top.sv - Scoreboard bench for des_system_top across three key/plaintext builds
module tb_des_system_top;
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT0  = 64'h123456789ABCDEF0;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;

    typedef struct {
        logic [63:0] ct0;
        logic [63:0] ct1;
        logic [63:0] ct2;
    } exp_t;

    logic clk, reset, start_btn;
    logic done0, done1, done2;
    exp_t sb[$];
    exp_t golden;
    int   total, bad;
    logic led_after;
    int   lat, low_cnt, high_cnt;

    des_system_top u0 (.clk(clk), .reset(reset), .start_btn(start_btn), .done_led(done0));
    des_system_top #(.KEY(KEY0), .INIT_PLAINTEXT(PT1)) u1 (
        .clk(clk), .reset(reset), .start_btn(start_btn), .done_led(done1));
    des_system_top #(.KEY(64'h0), .INIT_PLAINTEXT(64'h0)) u2 (
        .clk(clk), .reset(reset), .start_btn(start_btn), .done_led(done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Ascending vectors so that bit 1 of the standard is index 1.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] pt);
        logic [1:64] kin, bin, pre, outb;
        logic [1:56] cd;
        logic [1:28] c, d;
        logic [1:32] l, r, t, f, lt;
        logic [1:48] e, k, x;
        logic [5:0]  b;
        int          idx, nsh;
        kin = key;
        bin = pt;
        for (int i = 1; i <= 56; i++) cd[i] = kin[PC1_T[i-1]];
        c = cd[1:28];
        d = cd[29:56];
        for (int i = 1; i <= 32; i++) begin
            l[i] = bin[IP_T[i-1]];
            r[i] = bin[IP_T[i+31]];
        end
        for (int rnd = 1; rnd <= 16; rnd++) begin
            nsh = (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) ? 1 : 2;
            for (int s = 0; s < nsh; s++) begin
                c = {c[2:28], c[1]};
                d = {d[2:28], d[1]};
            end
            cd = {c, d};
            for (int i = 1; i <= 48; i++) begin
                k[i] = cd[PC2_T[i-1]];
                e[i] = r[E_T[i-1]];
            end
            x = e ^ k;
            for (int j = 0; j < 8; j++) begin
                b   = x[6*j+1 +: 6];
                idx = int'({b[5], b[0], b[4:1]});
                t[4*j+1 +: 4] = SBOX[j][255-4*idx -: 4];
            end
            for (int i = 1; i <= 32; i++) f[i] = t[P_T[i-1]];
            lt = l;
            l  = r;
            r  = lt ^ f;
        end
        pre = {r, l};
        for (int i = 1; i <= 64; i++) outb[i] = pre[FP_T[i-1]];
        return outb;
    endfunction

    // Drives one start, optionally pokes start again at edge `poke`, waits for done on u0.
    task automatic run_start(input bit push, input bit hold, input int poke,
                             output logic led_e0, output int latency);
        exp_t got_exp;
        @(posedge clk); #1;
        start_btn = 1'b1;
        if (push) sb.push_back(golden);
        @(posedge clk); #1;
        led_e0 = done0;
        if (!hold) start_btn = 1'b0;
        latency = 0;
        for (int n = 1; n <= 40 && latency == 0; n++) begin
            @(posedge clk); #1;
            if (done0) latency = n;
            if (poke != 0 && n == poke) start_btn = 1'b1;
            if (poke != 0 && n == poke + 1) start_btn = 1'b0;
        end
        if (push) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                got_exp = sb.pop_front();
                check("ct_default", u0.mem[1], got_exp.ct0);
                check("ct_kat_fips", u1.mem[1], got_exp.ct1);
                check("ct_kat_zero", u2.mem[1], got_exp.ct2);
                check("done1", 64'(done1), 64'd1);
                check("done2", 64'(done2), 64'd1);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        start_btn = 1'b0;

        check("model_kat_fips", des_ref(KEY0, PT1), 64'h85E813540F0AB405);
        check("model_kat_zero", des_ref(64'h0, 64'h0), 64'h8CA64DE9C1B123A7);
        golden.ct0 = des_ref(KEY0, PT0);
        golden.ct1 = 64'h85E813540F0AB405;
        golden.ct2 = 64'h8CA64DE9C1B123A7;

        repeat (10) @(posedge clk);
        #1;
        check("rst_done", 64'(done0), 64'd0);
        check("rst_state", 64'(u0.state_q), 64'd0);
        check("rst_round", 64'(u0.round_q), 64'd0);
        check("rst_mem1", u0.mem[1], 64'h0);
        check("rst_mem0", u0.mem[0], PT0);
        reset = 1'b1;

        // Abort at round 8: nothing written, back to IDLE.
        @(posedge clk); #1;
        start_btn = 1'b1;
        @(posedge clk); #1;
        start_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_round", 64'(u0.round_q), 64'd8);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_done", 64'(done0), 64'd0);
        check("abort_state", 64'(u0.state_q), 64'd0);
        check("abort_rnd0", 64'(u0.round_q), 64'd0);
        check("abort_l", 64'(u0.l_q), 64'd0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_mem1", u0.mem[1], 64'h0);
        check("abort_mem1_u1", u1.mem[1], 64'h0);
        check("abort_idle_done", 64'(done0), 64'd0);

        // Plain runs on all three builds.
        run_start(1'b1, 1'b0, 0, led_after, lat);
        check("run1_e0_led", 64'(led_after), 64'd0);
        check("run1_latency", 64'(lat), 64'd21);
        check("run1_mem0", u0.mem[0], PT0);

        // Extra start pulse mid-round is ignored.
        run_start(1'b1, 1'b0, 7, led_after, lat);
        check("poke_latency", 64'(lat), 64'd21);

        // Held start: one run, done stays lit.
        run_start(1'b1, 1'b1, 0, led_after, lat);
        check("hold_latency", 64'(lat), 64'd21);
        low_cnt = 0;
        for (int n = 0; n < 75; n++) begin
            @(posedge clk); #1;
            if (!done0) low_cnt++;
        end
        check("hold_done_stays", 64'(low_cnt), 64'd0);
        check("hold_state_done", 64'(u0.state_q), 64'd6);
        start_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_done_after_release", 64'(done0), 64'd1);
        run_start(1'b1, 1'b0, 0, led_after, lat);
        check("restart_drop", 64'(led_after), 64'd0);
        check("restart_latency", 64'(lat), 64'd21);

        // Start held across reset release must not trigger.
        @(posedge clk); #1;
        reset = 1'b0;
        start_btn = 1'b1;
        @(posedge clk); #1;
        check("rst_clears_done", 64'(done0), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        high_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (done0 || u0.state_q != 0) high_cnt++;
        end
        check("held_no_trigger", 64'(high_cnt), 64'd0);
        start_btn = 1'b0;
        repeat (2) @(posedge clk);
        run_start(1'b1, 1'b0, 0, led_after, lat);
        check("post_held_latency", 64'(lat), 64'd21);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
